cnu_sched: RTL and testbench
============================

// Module: cnu_sched
// PURPOSE
//  Layered-decoding scheduler for the check-node unit (CNU). Walks check-node rows 0..ROWS-1 once
//  per iteration: issues message-memory reads, drives the CNU enable aligned with read data, and
//  issues write-backs aligned with CNU results. Ends decoding on max iterations, all-rows-parity-OK
//  (early termination) or abort. Sits between the top-level decoder control and the CNU + q/r RAMs.
// PARAMETERS
//  ROWS     8   check-node rows (layers) per iteration, >=2
//  ADDR_W   3   row address width, 2**ADDR_W >= ROWS
//  ITER_W   5   iteration counter / max_iter width
//  CNU_LAT  2   cycles from CNU en-qualified input to valid r output, >=1
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst        in   1       asynchronous reset, active-high
//  start      in   1       begin decoding; sampled only in IDLE
//  max_iter   in   ITER_W  iteration limit, captured on accepted start; 0 treated as 1
//  abort      in   1       cancel decoding from any state
//  par_ok     in   1       row parity satisfied (CNU sign product = 0); valid only while wr_en=1
//  busy       out  1       high from cycle after accepted start until return to IDLE
//  done       out  1       one-cycle pulse on normal completion
//  converged  out  1       with done: 1 = early termination, 0 = limit reached; held until next start
//  iter_cnt   out  ITER_W  completed iterations; held after done until next start
//  rd_en      out  1       read q messages of row rd_addr
//  rd_addr    out  ADDR_W  row being read
//  cnu_en     out  1       CNU enable; asserted 1 cycle after rd_en (1-cycle RAM read latency)
//  wr_en      out  1       write CNU result r for row wr_addr
//  wr_addr    out  ADDR_W  row being written
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE; busy, done, converged, rd_en, cnu_en, wr_en = 0;
//    iter_cnt, rd_addr, wr_addr = 0; pipeline valid/address shift registers cleared.
//  - FSM: IDLE -> ISSUE (start=1) -> DRAIN (after row ROWS-1 issued) -> CHECK (pipeline empty)
//    -> ISSUE (next iteration) | IDLE (finish). abort in any state -> IDLE next edge.
//  - ISSUE: rd_en=1 for ROWS consecutive cycles, rd_addr 0..ROWS-1. No stalls.
//  - Pipeline: cnu_en = rd_en delayed 1 cycle. wr_en = cnu_en delayed CNU_LAT cycles. wr_addr = rd_addr
//    delayed 1+CNU_LAT cycles. Implemented as valid + address shift registers.
//  - DRAIN: rd_en=0. Wait until the last wr_en has been issued. No row of iteration k+1 is read before
//    all rows of iteration k are written (layered data hazard).
//  - Parity accumulator: set to 1 on ISSUE entry. ANDed with par_ok on every wr_en cycle.
//  - CHECK (1 cycle): iter_cnt += 1.
//    - Accumulator=1: finish with converged=1.
//    - Else if new iter_cnt == effective max_iter: finish with converged=0.
//    - Else: start next ISSUE.
//    - Finish: done=1 for one cycle with state IDLE; busy=0 in the same cycle.
//  - Iteration period = ROWS + CNU_LAT + 2 cycles.
//  - start while busy: ignored. start with abort in IDLE: abort wins, start ignored.
//  - abort: next edge clears pipeline valids, so rd_en/cnu_en/wr_en = 0. No done pulse.
//    busy=0; iter_cnt holds its value.
//  - Accepted start clears iter_cnt and converged.
//  - rd_addr wraps ROWS-1 -> 0 only via a new ISSUE entry, never mid-iteration.
// TESTING (ROWS=8, CNU_LAT=2, start accepted at edge 0, cycle n = after edge n)
//  1. max_iter=1, par_ok=0: rd_en cycles 1-8 (addr 0..7); cnu_en 2-9; wr_en 4-11 (addr 0..7);
//     done + converged=0 at cycle 13, iter_cnt=1.
//  2. max_iter=3, par_ok=0: rd_en bursts start cycles 1, 13, 25; done cycle 37, iter_cnt=3, converged=0.
//  3. max_iter=10, par_ok=1 from 2nd iteration: done at cycle 25, converged=1, iter_cnt=2.
//     A single par_ok=0 row in iteration 2 -> continues to iteration 3.
//  4. abort at cycle 6: cycle 7 has rd_en=cnu_en=wr_en=0, busy=0; no done pulse ever.
//     New start then runs normally from rd_addr 0.
//  5. start re-pulsed while busy and max_iter changed mid-run: no effect; max_iter=0 -> 1 iteration.
//  6. Async rst asserted mid-ISSUE between edges: all outputs 0 immediately. After release, IDLE until start.

Source files
------------

// File: rtl/cnu_sched_if.sv
// Handshake bundle between decoder control / CNU datapath (master) and the
// layered-decoding scheduler (slave).
interface cnu_sched_if #(
  parameter int ADDR_W = 3,
  parameter int ITER_W = 5
);
  logic              start;
  logic [ITER_W-1:0] max_iter;
  logic              abort;
  logic              par_ok;
  logic              busy;
  logic              done;
  logic              converged;
  logic [ITER_W-1:0] iter_cnt;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              cnu_en;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;

  modport master (
    output start, max_iter, abort, par_ok,
    input  busy, done, converged, iter_cnt, rd_en, rd_addr, cnu_en, wr_en, wr_addr
  );

  modport slave (
    input  start, max_iter, abort, par_ok,
    output busy, done, converged, iter_cnt, rd_en, rd_addr, cnu_en, wr_en, wr_addr
  );
endinterface

// File: rtl/cnu_sched.sv
// Layered-decoding scheduler: walks check-node rows once per iteration, aligns
// CNU enable and write-back with the read pipeline, and ends on limit/parity/abort.
module cnu_sched #(
  parameter int ROWS    = 8,
  parameter int ADDR_W  = 3,
  parameter int ITER_W  = 5,
  parameter int CNU_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  cnu_sched_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, CHECK} state_t;

  state_t            state;
  logic [ADDR_W-1:0] row_cnt;
  logic [ITER_W-1:0] max_eff;
  logic [ITER_W-1:0] iter_cnt;
  logic              par_acc;
  logic              busy;
  logic              done;
  logic              converged;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  // vld[0] is cnu_en, vld[CNU_LAT] is wr_en; addr_pipe tracks the row alongside.
  logic [CNU_LAT:0]  vld;
  logic [ADDR_W-1:0] addr_pipe [CNU_LAT+1];

  logic [ITER_W-1:0] iter_next;
  logic              pipe_busy;

  assign iter_next = iter_cnt + ITER_W'(1);
  // Everything upstream of the write stage is empty: the write in flight is the last one.
  assign pipe_busy = rd_en | (|vld[CNU_LAT-1:0]);

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.converged = converged;
  assign bus.iter_cnt  = iter_cnt;
  assign bus.rd_en     = rd_en;
  assign bus.rd_addr   = rd_addr;
  assign bus.cnu_en    = vld[0];
  assign bus.wr_en     = vld[CNU_LAT];
  assign bus.wr_addr   = addr_pipe[CNU_LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      row_cnt   <= '0;
      max_eff   <= ITER_W'(1);
      iter_cnt  <= '0;
      par_acc   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      converged <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      vld       <= '0;
      // NOTE: the address shift register is small flop storage, not RAM, so it is
      // reset like any other state to keep wr_addr at 0 out of reset.
      for (int i = 0; i <= CNU_LAT; i++) addr_pipe[i] <= '0;
    end else begin
      // NOTE: non-blocking throughout; later assignments in this block override the
      // defaults below, which is how abort and FSM decisions take priority.
      done         <= 1'b0;
      rd_en        <= 1'b0;
      vld          <= {vld[CNU_LAT-1:0], rd_en};
      addr_pipe[0] <= rd_addr;
      for (int i = 1; i <= CNU_LAT; i++) addr_pipe[i] <= addr_pipe[i-1];
      if (vld[CNU_LAT]) par_acc <= par_acc & bus.par_ok;

      if (bus.abort) begin
        state <= IDLE;
        busy  <= 1'b0;
        vld   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              state     <= ISSUE;
              busy      <= 1'b1;
              iter_cnt  <= '0;
              converged <= 1'b0;
              max_eff   <= (bus.max_iter == '0) ? ITER_W'(1) : bus.max_iter;
              row_cnt   <= '0;
              par_acc   <= 1'b1;
            end
          end
          ISSUE: begin
            rd_en   <= 1'b1;
            rd_addr <= row_cnt;
            row_cnt <= row_cnt + ADDR_W'(1);
            if (row_cnt == ADDR_W'(ROWS - 1)) state <= DRAIN;
          end
          DRAIN: begin
            if (!pipe_busy) state <= CHECK;
          end
          CHECK: begin
            iter_cnt <= iter_next;
            if (par_acc || iter_next == max_eff) begin
              state     <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
              converged <= par_acc;
            end else begin
              // Issue row 0 on the transition itself so iterations stay back to back.
              state   <= ISSUE;
              rd_en   <= 1'b1;
              rd_addr <= '0;
              row_cnt <= ADDR_W'(1);
              par_acc <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cnu_sched.sv
// Self-checking bench for cnu_sched: per-cycle comparison against a timeline
// model derived from row count, latency and the per-row parity table.
module tb_cnu_sched;
  localparam int ROWS    = 8;
  localparam int ADDR_W  = 3;
  localparam int ITER_W  = 5;
  localparam int CNU_LAT = 2;
  localparam int PERIOD  = ROWS + CNU_LAT + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  bit   par_tab [0:15][0:ROWS-1];

  cnu_sched_if #(.ADDR_W(ADDR_W), .ITER_W(ITER_W)) bus ();

  cnu_sched #(.ROWS(ROWS), .ADDR_W(ADDR_W), .ITER_W(ITER_W), .CNU_LAT(CNU_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic fill_par(input int first_good, input int permille_one);
    for (int it = 0; it < 16; it++)
      for (int r = 0; r < ROWS; r++)
        par_tab[it][r] = (first_good >= 0 && it >= first_good) ? 1'b1
                       : (first_good >= 0) ? 1'b0
                       : ($urandom_range(999, 0) < permille_one);
  endtask

  // One decoding run, start accepted at edge 0; abort_at < 0 means no abort.
  task automatic run(input int mi, input int abort_at, input bit poke);
    int eff, n, done_c, end_c, tt, cnt, ph;
    bit conv, all_ok, ab, e_rd, e_cnu, e_wr;
    int e_rd_a, e_wr_a, wr_it;
    eff  = (mi == 0) ? 1 : mi;
    n    = eff;
    conv = 1'b0;
    for (int k = 1; k <= eff; k++) begin
      all_ok = 1'b1;
      for (int r = 0; r < ROWS; r++) all_ok &= par_tab[k-1][r];
      if (all_ok) begin n = k; conv = 1'b1; break; end
    end
    done_c = PERIOD * n + 1;
    ab     = (abort_at >= 0);
    end_c  = ab ? abort_at + 3 : done_c + 2;

    @(negedge clk);
    bus.start = 1'b1; bus.max_iter = ITER_W'(mi); bus.abort = 1'b0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int c = 0; c <= end_c; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      tt = (ab && c > abort_at) ? abort_at : c;
      e_rd = 0; e_cnu = 0; e_wr = 0; e_rd_a = 0; e_wr_a = 0; wr_it = 0; cnt = 0;
      for (int it = 0; it < n; it++) begin
        if (!(ab && c > abort_at)) begin
          ph = c - 1 - PERIOD * it;
          if (ph >= 0 && ph < ROWS) begin e_rd = 1; e_rd_a = ph; end
          if (ph - 1 >= 0 && ph - 1 < ROWS) e_cnu = 1;
          if (ph - 1 - CNU_LAT >= 0 && ph - 1 - CNU_LAT < ROWS) begin
            e_wr = 1; e_wr_a = ph - 1 - CNU_LAT; wr_it = it;
          end
        end
        if (PERIOD * it + PERIOD + 1 <= tt) cnt++;
      end
      check("rd_en", int'(bus.rd_en), int'(e_rd));
      check("cnu_en", int'(bus.cnu_en), int'(e_cnu));
      check("wr_en", int'(bus.wr_en), int'(e_wr));
      if (e_rd) check("rd_addr", int'(bus.rd_addr), e_rd_a);
      if (e_wr) check("wr_addr", int'(bus.wr_addr), e_wr_a);
      check("busy", int'(bus.busy), int'(c < done_c && !(ab && c > abort_at)));
      check("done", int'(bus.done), int'(c == done_c && !ab));
      check("iter_cnt", int'(bus.iter_cnt), cnt);
      check("converged", int'(bus.converged), int'(c >= done_c && !ab && conv));
      // par_ok is only meaningful during a write; elsewhere it carries noise.
      bus.par_ok = e_wr ? par_tab[wr_it][e_wr_a] : 1'($urandom);
      bus.abort  = ab && (c == abort_at);
      bus.start  = poke && (c == 3 || c == 15);
      if (bus.start) bus.max_iter = ITER_W'($urandom_range(1, 0));
    end
    bus.start = 1'b0; bus.abort = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.abort = 1'b0; bus.par_ok = 1'b0; bus.max_iter = '0;
    #12;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_rd_en", int'(bus.rd_en), 0);
    check("rst_wr_en", int'(bus.wr_en), 0);
    check("rst_iter_cnt", int'(bus.iter_cnt), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    fill_par(99, 0);  run(1, -1, 1'b0);   // limit after one iteration
    fill_par(99, 0);  run(3, -1, 1'b0);   // three back-to-back iterations
    fill_par(1, 0);   run(10, -1, 1'b0);  // converges in iteration 2
    fill_par(2, 0);
    for (int r = 0; r < ROWS; r++) par_tab[1][r] = 1'b1;
    par_tab[1][$urandom_range(ROWS-1, 0)] = 1'b0;
    run(10, -1, 1'b0);                    // one bad row pushes to iteration 3
    fill_par(99, 0);  run(2, 6, 1'b0);    // abort mid-issue
    fill_par(99, 0);  run(1, -1, 1'b0);   // clean restart after abort
    fill_par(99, 0);  run(2, -1, 1'b1);   // start/max_iter poked while busy
    fill_par(99, 0);  run(0, -1, 1'b0);   // max_iter 0 behaves as 1

    // start together with abort in IDLE must be ignored
    @(negedge clk); bus.start = 1'b1; bus.abort = 1'b1; bus.max_iter = 5'd2;
    @(posedge clk); #1 bus.start = 1'b0; bus.abort = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("start_abort_busy", int'(bus.busy), 0);
    check("start_abort_rd_en", int'(bus.rd_en), 0);

    // asynchronous reset mid-issue, after a converged run left converged=1
    fill_par(0, 0); run(4, -1, 1'b0);
    @(negedge clk); bus.start = 1'b1; bus.max_iter = 5'd3;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_rd_en", int'(bus.rd_en), 0);
    check("arst_cnu_en", int'(bus.cnu_en), 0);
    check("arst_wr_en", int'(bus.wr_en), 0);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_rd_addr", int'(bus.rd_addr), 0);
    check("arst_converged", int'(bus.converged), 0);
    check("arst_iter_cnt", int'(bus.iter_cnt), 0);
    #3 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("post_rst_busy", int'(bus.busy), 0);
    check("post_rst_rd_en", int'(bus.rd_en), 0);

    for (int i = 0; i < 6; i++) begin
      fill_par(-1, 920);
      run(int'($urandom_range(5, 0)), -1, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
